// File: rtl/rr_mux3_arbiter.sv
// rtl/rr_mux3_arbiter.sv - round-robin arbiter driving a shared 3:1 registered mux
module rr_mux3_arbiter #(
  parameter int W        = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   req,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [2:0]   gnt,
  output logic [1:0]   s,
  output logic [W-1:0] o,
  output logic         o_valid
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  state_t       state, state_nxt;
  logic [1:0]   last, last_nxt;
  logic [3:0]   cnt, cnt_nxt;
  logic [2:0]   gnt_nxt;
  logic [1:0]   s_nxt;
  logic [W-1:0] o_nxt;

  logic [2:0]   owner_mask;
  logic [2:0]   others;
  logic         keep;
  logic         take;
  logic [1:0]   pick;

  // Index after i in the 0->1->2->0 ring.
  function automatic logic [1:0] succ(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // First set bit of m scanning the ring from start; m must be non-zero.
  function automatic logic [1:0] first_from(input logic [1:0] start, input logic [2:0] m);
    logic [2:0] r;
    logic [2:0] sum;
    case (start)
      2'd0:    r = m;
      2'd1:    r = {m[0], m[2], m[1]};
      default: r = {m[1], m[0], m[2]};
    endcase
    sum = {1'b0, start} + (r[0] ? 3'd0 : (r[1] ? 3'd1 : 3'd2));
    return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  endfunction

  // Data of requester idx; index 3 is never selected.
  function automatic logic [W-1:0] sel_data(input logic [1:0] idx);
    case (idx)
      2'd0:    return a;
      2'd1:    return b;
      default: return c;
    endcase
  endfunction

  // State, grant, select, data and arbitration bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 3'b000;
      s     <= 2'd0;
      o     <= '0;
      cnt   <= 4'd0;
      last  <= 2'd2;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      s     <= s_nxt;
      o     <= o_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

  // Arbitration decision: keep the current owner, hand over to the next requester, or go idle.
  always_comb begin
    owner_mask = (state == BUSY) ? (3'b001 << s) : 3'b000;
    others     = req & ~owner_mask;
    keep       = (state == BUSY) && (|(req & owner_mask)) &&
                 ((cnt < HOLD_MAX) || (others == 3'b000));
    take       = !keep && (|others);
    pick       = first_from(succ(last), others);
    state_nxt  = (keep || take) ? BUSY : IDLE;
  end

  // Next registered outputs; s and o hold when nobody owns the mux.
  always_comb begin
    gnt_nxt  = 3'b000;
    s_nxt    = s;
    o_nxt    = o;
    cnt_nxt  = 4'd0;
    last_nxt = last;
    if (keep) begin
      gnt_nxt = gnt;
      o_nxt   = sel_data(s);
      cnt_nxt = (cnt < HOLD_MAX) ? cnt + 4'd1 : cnt;
    end else if (take) begin
      gnt_nxt  = 3'b001 << pick;
      s_nxt    = pick;
      o_nxt    = sel_data(pick);
      cnt_nxt  = 4'd1;
      last_nxt = pick;
    end
  end

  assign o_valid = |gnt;

endmodule
